// File: rtl/lifo_stack.sv
// LIFO stack with a registered top-of-stack, occupancy count, almost-full
// threshold, replace-top on push+pop, synchronous clear and sticky error flags.
module lifo_stack #(
  parameter  int DATA_W    = 8,
  parameter  int DEPTH     = 16,
  parameter  int AFULL_THR = 14,
  localparam int CW        = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              clear,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] datain,
  output logic [DATA_W-1:0] dataout,
  output logic              val,
  output logic              full,
  output logic              afull,
  output logic [CW-1:0]     count,
  output logic              ovf,
  output logic              udf
);

  // Entries below the top live in r_mem; DEPTH==2 still needs a 1-bit index.
  localparam int AW = (DEPTH > 2) ? $clog2(DEPTH - 1) : 1;

  logic [DATA_W-1:0] r_mem [DEPTH-1];
  logic [DATA_W-1:0] r_tos;
  logic [CW-1:0]     r_count;
  logic              r_ovf;
  logic              r_udf;

  logic              w_empty;
  logic              w_one;
  logic              w_full;
  logic              w_do_push;
  logic              w_do_rep;
  logic              w_do_pop;
  logic              w_set_ovf;
  logic              w_set_udf;
  logic              w_mem_we;
  logic [AW-1:0]     w_wr_idx;
  logic [AW-1:0]     w_rd_idx;
  logic [DATA_W-1:0] w_below;
  logic [DATA_W-1:0] w_tos_nxt;
  logic [CW-1:0]     w_count_nxt;

  assign w_empty = (r_count == '0);
  assign w_one   = (r_count == CW'(1));
  assign w_full  = (r_count == CW'(DEPTH));

  // Push+pop on an empty stack degenerates into a plain push (plus underflow).
  assign w_do_push = !clear && push && (!pop || w_empty) && !w_full;
  assign w_do_rep  = !clear && push && pop && !w_empty;
  assign w_do_pop  = !clear && pop && !push && !w_empty;
  assign w_set_ovf = !clear && push && !pop && w_full;
  assign w_set_udf = !clear && pop && w_empty;

  assign w_wr_idx = AW'(r_count - CW'(1));
  assign w_rd_idx = AW'(r_count - CW'(2));
  assign w_mem_we = w_do_push && !w_empty;
  assign w_below  = (w_empty || w_one) ? '0 : r_mem[w_rd_idx];

  always_comb begin
    w_tos_nxt   = r_tos;
    w_count_nxt = r_count;
    if (clear) begin
      w_tos_nxt   = '0;
      w_count_nxt = '0;
    end else if (w_do_rep) begin
      w_tos_nxt   = datain;
    end else if (w_do_push) begin
      w_tos_nxt   = datain;
      w_count_nxt = r_count + CW'(1);
    end else if (w_do_pop) begin
      w_tos_nxt   = w_below;
      w_count_nxt = r_count - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_tos   <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
      r_udf   <= 1'b0;
    end else begin
      r_tos   <= w_tos_nxt;
      r_count <= w_count_nxt;
      if (clear) begin
        r_ovf <= 1'b0;
        r_udf <= 1'b0;
      end else begin
        if (w_set_ovf) r_ovf <= 1'b1;
        if (w_set_udf) r_udf <= 1'b1;
      end
    end
  end

  // Storage is deliberately not reset; count alone defines what is valid.
  always_ff @(posedge clk) begin
    if (w_mem_we) r_mem[w_wr_idx] <= r_tos;
  end

  assign dataout = r_tos;
  assign count   = r_count;
  assign val     = !w_empty;
  assign full    = w_full;
  assign afull   = (r_count >= CW'(AFULL_THR));
  assign ovf     = r_ovf;
  assign udf     = r_udf;

endmodule
